// File: rtl/ring_painter.sv
`default_nettype none
// ==========================================================================
// ring_painter : animated ping-pong ring plus panel border, 2-clk pixel latency
// Rev 1.0
// ==========================================================================
module ring_painter #(
  parameter int         COORD_W     = 6,
  parameter int         CX          = 32,
  parameter int         CY          = 32,
  parameter int         R_MIN       = 8,
  parameter int         R_MAX       = 24,
  parameter int         THICK       = 1,
  parameter int         STEP_FRAMES = 4,
  parameter logic [2:0] RING_RGB    = 3'b010,
  parameter logic [2:0] BORD_RGB    = 3'b001
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [9:0]         frame,
  input  logic [7:0]         subframe,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               anim_en,
  output logic [2:0]         rgb
);

  localparam int SQ_W = 2 * COORD_W;
  localparam int TH_W = 2 * COORD_W + 2;
  localparam int SC_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  localparam logic [COORD_W-1:0] CMAX    = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] RAD_MIN = COORD_W'(R_MIN);
  localparam logic [COORD_W-1:0] RAD_MAX = COORD_W'(R_MAX);
  localparam logic [COORD_W-1:0] RAD_ONE = COORD_W'(1);
  localparam logic [SC_W-1:0]    SC_LAST = SC_W'(STEP_FRAMES - 1);
  localparam logic [SC_W-1:0]    SC_ONE  = SC_W'(1);
  localparam logic [TH_W-1:0]    LO_RST  = TH_W'(R_MIN * R_MIN);
  localparam logic [TH_W-1:0]    HI_RST  = TH_W'((R_MIN + THICK) * (R_MIN + THICK));
  localparam logic [TH_W-1:0]    THICK_W = TH_W'(THICK);
  localparam logic [SQ_W-1:0]    CX_W    = SQ_W'(CX);
  localparam logic [SQ_W-1:0]    CY_W    = SQ_W'(CY);

  typedef enum logic [0:0] {GROW = 1'b0, SHRINK = 1'b1} dir_t;

  dir_t               dir, dir_nxt;
  logic [COORD_W-1:0] rad, rad_nxt;
  logic [SC_W-1:0]    stepcnt, stepcnt_nxt;
  logic [9:0]         frame_q;
  logic               frame_evt;
  logic [TH_W-1:0]    rad_w, lo, hi;
  logic [SQ_W-1:0]    dx, dy, dx2, dy2;
  logic               b1;
  logic [TH_W-1:0]    r2;
  logic               ring;
  logic               unused_subframe;

  assign unused_subframe = ^subframe;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dir     <= GROW;
      rad     <= RAD_MIN;
      stepcnt <= '0;
      frame_q <= '0;
      lo      <= LO_RST;
      hi      <= HI_RST;
    end else begin
      dir     <= dir_nxt;
      rad     <= rad_nxt;
      stepcnt <= stepcnt_nxt;
      frame_q <= frame;
      lo      <= rad_w * rad_w;
      hi      <= (rad_w + THICK_W) * (rad_w + THICK_W);
    end
  end

  assign rad_w = TH_W'(rad);

  always_comb begin
    dir_nxt     = dir;
    rad_nxt     = rad;
    stepcnt_nxt = stepcnt;
    frame_evt   = anim_en && (frame != frame_q);
    if (frame_evt) begin
      if (stepcnt == SC_LAST) begin
        stepcnt_nxt = '0;
        if (R_MIN != R_MAX) begin
          case (dir)
            GROW: begin
              if (rad == RAD_MAX) begin
                dir_nxt = SHRINK;
                rad_nxt = rad - RAD_ONE;
              end else begin
                rad_nxt = rad + RAD_ONE;
              end
            end
            SHRINK: begin
              if (rad == RAD_MIN) begin
                dir_nxt = GROW;
                rad_nxt = rad + RAD_ONE;
              end else begin
                rad_nxt = rad - RAD_ONE;
              end
            end
            default: ;
          endcase
        end
      end else begin
        stepcnt_nxt = stepcnt + SC_ONE;
      end
    end
  end

  // Offsets are taken modulo 2**SQ_W; the square of a wrapped offset equals the true square.
  assign dx = CX_W - SQ_W'(x);
  assign dy = CY_W - SQ_W'(y);

  assign r2   = TH_W'(dx2) + TH_W'(dy2);
  assign ring = (lo <= r2) && (r2 < hi);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dx2 <= '0;
      dy2 <= '0;
      b1  <= 1'b0;
      rgb <= 3'b000;
    end else begin
      dx2 <= dx * dx;
      dy2 <= dy * dy;
      b1  <= (x == '0) || (x == CMAX) || (y == '0) || (y == CMAX);
      rgb <= (ring ? RING_RGB : 3'b000) | (b1 ? BORD_RGB : 3'b000);
    end
  end

endmodule
`default_nettype wire
